// File: rtl/lcd_pattern_driver.sv
// DE-mode LCD timing generator with solid/bars/checker/external pixel sources.
// Define LCD_SYNC_OUT_EN to add active-low o_hsync/o_vsync outputs.
module lcd_pattern_driver #(
    parameter int unsigned H_ACTIVE   = 800,
    parameter int unsigned H_BACK     = 46,
    parameter int unsigned H_FRONT    = 210,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_BACK     = 23,
    parameter int unsigned V_FRONT    = 22,
    parameter int unsigned CHECK_LOG2 = 5,
    parameter int unsigned XW         = 11,
    parameter int unsigned YW         = 10
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [1:0]    i_mode,
    input  logic [23:0]   i_color,
    input  logic [23:0]   i_pixel,
    output logic          o_lcd_clk,
    output logic          o_req,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_frame_start,
    output logic          o_data_enable,
    output logic [7:0]    o_red,
    output logic [7:0]    o_green,
    output logic [7:0]    o_blue
`ifdef LCD_SYNC_OUT_EN
    ,
    output logic          o_hsync,
    output logic          o_vsync
`endif
);

    localparam int unsigned H_TOTAL = H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned V_TOTAL = V_BACK + V_ACTIVE + V_FRONT;
    localparam int unsigned HW      = $clog2(H_TOTAL + 1);
    localparam int unsigned VW      = $clog2(V_TOTAL + 1);
    localparam int unsigned BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          active;
    logic [XW-1:0] bar_cnt;
    logic [2:0]    bar_idx;
    logic [1:0]    lat_mode;
    logic [23:0]   lat_color;
    logic [23:0]   bar_rgb;
    logic [23:0]   pix;

    assign o_lcd_clk = ~i_clk;
    assign active    = (h >= HW'(H_BACK)) && (h < HW'(H_BACK + H_ACTIVE)) &&
                       (v >= VW'(V_BACK)) && (v < VW'(V_BACK + V_ACTIVE));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h <= '0;
            v <= '0;
        end else if (h == HW'(H_TOTAL - 1)) begin
            h <= '0;
            v <= (v == VW'(V_TOTAL - 1)) ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    // Bar index follows o_x via a divide-free counter restarted at each line's first pixel.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_req         <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_frame_start <= 1'b0;
            bar_cnt       <= '0;
            bar_idx       <= '0;
        end else begin
            o_req         <= active;
            o_frame_start <= (h == '0) && (v == '0);
            if (active) begin
                o_x <= XW'(h - HW'(H_BACK));
                o_y <= YW'(v - VW'(V_BACK));
            end else begin
                o_x <= '0;
                o_y <= '0;
            end
            if (!active || h == HW'(H_BACK)) begin
                bar_cnt <= '0;
                bar_idx <= '0;
            end else if (bar_cnt == XW'(BAR_W - 1)) begin
                bar_cnt <= '0;
                bar_idx <= (bar_idx == 3'd7) ? 3'd7 : bar_idx + 3'd1;
            end else begin
                bar_cnt <= bar_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lat_mode  <= '0;
            lat_color <= '0;
        end else if (o_frame_start) begin
            lat_mode  <= i_mode;
            lat_color <= i_color;
        end
    end

    always_comb begin
        bar_rgb = '0;
        unique case (bar_idx)
            3'd0: bar_rgb = 24'hFFFFFF;
            3'd1: bar_rgb = 24'hFFFF00;
            3'd2: bar_rgb = 24'h00FFFF;
            3'd3: bar_rgb = 24'h00FF00;
            3'd4: bar_rgb = 24'hFF00FF;
            3'd5: bar_rgb = 24'hFF0000;
            3'd6: bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    always_comb begin
        pix = '0;
        unique case (lat_mode)
            2'd0: pix = lat_color;
            2'd1: pix = bar_rgb;
            2'd2: pix = (o_x[CHECK_LOG2] ^ o_y[CHECK_LOG2]) ? 24'h000000 : lat_color;
            default: pix = i_pixel;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data_enable <= 1'b0;
            {o_red, o_green, o_blue} <= '0;
        end else begin
            o_data_enable <= o_req;
            {o_red, o_green, o_blue} <= o_req ? pix : 24'h000000;
        end
    end

`ifdef LCD_SYNC_OUT_EN
    localparam int unsigned HS_W = (H_BACK / 2 >= 1) ? H_BACK / 2 : 1;
    localparam int unsigned VS_W = (V_BACK / 2 >= 1) ? V_BACK / 2 : 1;

    logic hs1, vs1;

    // Two register stages keep sync aligned with DE/RGB.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hs1     <= 1'b0;
            vs1     <= 1'b0;
            o_hsync <= 1'b0;
            o_vsync <= 1'b0;
        end else begin
            hs1     <= !(h < HW'(HS_W));
            vs1     <= !(v < VW'(VS_W));
            o_hsync <= hs1;
            o_vsync <= vs1;
        end
    end
`endif

endmodule

// File: tb/tb_lcd_pattern_driver.sv
// Directed self-checking bench for lcd_pattern_driver on an 8x4 active panel.
module tb_lcd_pattern_driver;

    localparam int HA = 8, HB = 2, HF = 2, VA = 4, VB = 1, VF = 1;
    localparam int HT = HB + HA + HF;
    localparam int FT = HT * (VB + VA + VF);

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  i_mode;
    logic [23:0] i_color;
    logic [23:0] i_pixel;
    logic        o_lcd_clk, o_req, o_frame_start, o_data_enable;
    logic [10:0] o_x;
    logic [9:0]  o_y;
    logic [7:0]  o_red, o_green, o_blue;
`ifdef LCD_SYNC_OUT_EN
    logic        o_hsync, o_vsync;
`endif

    int          checks = 0;
    int          failures = 0;
    int          k = 0;
    int          base = 0;
    int          de_count = 0;
    logic [1:0]  m_mode = 2'd0;
    logic [23:0] m_color = 24'h0;
    bit          pend = 1'b0;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    always #5 clk = ~clk;

    lcd_pattern_driver #(
        .H_ACTIVE(HA), .H_BACK(HB), .H_FRONT(HF),
        .V_ACTIVE(VA), .V_BACK(VB), .V_FRONT(VF),
        .CHECK_LOG2(1), .XW(11), .YW(10)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_mode(i_mode),
        .i_color(i_color),
        .i_pixel(i_pixel),
        .o_lcd_clk(o_lcd_clk),
        .o_req(o_req),
        .o_x(o_x),
        .o_y(o_y),
        .o_frame_start(o_frame_start),
        .o_data_enable(o_data_enable),
        .o_red(o_red),
        .o_green(o_green),
        .o_blue(o_blue)
`ifdef LCD_SYNC_OUT_EN
        ,
        .o_hsync(o_hsync),
        .o_vsync(o_vsync)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit act(input int c);
        int cc, hh, vv;
        if (c < 0) return 1'b0;
        cc = c % FT;
        hh = cc % HT;
        vv = cc / HT;
        return (hh >= HB) && (hh < HB + HA) && (vv >= VB) && (vv < VB + VA);
    endfunction

    task automatic check_blank(input string tag);
        chk({tag, "_req"}, {31'd0, o_req}, 32'd0);
        chk({tag, "_fs"}, {31'd0, o_frame_start}, 32'd0);
        chk({tag, "_de"}, {31'd0, o_data_enable}, 32'd0);
        chk({tag, "_x"}, {21'd0, o_x}, 32'd0);
        chk({tag, "_y"}, {22'd0, o_y}, 32'd0);
        chk({tag, "_rgb"}, {8'd0, o_red, o_green, o_blue}, 32'd0);
`ifdef LCD_SYNC_OUT_EN
        chk({tag, "_hs"}, {31'd0, o_hsync}, 32'd0);
        chk({tag, "_vs"}, {31'd0, o_vsync}, 32'd0);
`endif
    endtask

    // One clock: model expectations, compare at the falling edge, then answer the pixel request.
    task automatic step();
        int c1, c2, h1, v1, h2, v2, x2, y2;
        bit e_req, e_de, e_fs;
        logic [23:0] e_rgb;
        logic [10:0] e_x;
        logic [9:0]  e_y;
        @(posedge clk);
        k++;
        c1 = k - 1 - base;
        c2 = k - 2 - base;
        e_req = act(c1);
        e_fs  = (c1 % FT) == 0;
        h1 = (c1 % FT) % HT;
        v1 = (c1 % FT) / HT;
        e_x = e_req ? 11'(h1 - HB) : 11'd0;
        e_y = e_req ? 10'(v1 - VB) : 10'd0;
        e_de = act(c2);
        h2 = (c2 < 0) ? 0 : (c2 % FT) % HT;
        v2 = (c2 < 0) ? 0 : (c2 % FT) / HT;
        x2 = h2 - HB;
        y2 = v2 - VB;
        e_rgb = 24'h0;
        if (e_de) begin
            case (m_mode)
                2'd0: e_rgb = m_color;
                2'd1: e_rgb = bars[x2];
                2'd2: e_rgb = (((x2 >> 1) ^ (y2 >> 1)) & 1) != 0 ? 24'h0 : m_color;
                default: e_rgb = {8'h00, 8'(y2), 8'(x2)};
            endcase
        end
        if (pend) begin
            m_mode  = i_mode;
            m_color = i_color;
        end
        pend = e_fs;
        @(negedge clk);
        chk("lcd_clk", {31'd0, o_lcd_clk}, 32'd1);
        chk("frame_start", {31'd0, o_frame_start}, {31'd0, e_fs});
        chk("req", {31'd0, o_req}, {31'd0, e_req});
        chk("x", {21'd0, o_x}, {21'd0, e_x});
        chk("y", {22'd0, o_y}, {22'd0, e_y});
        chk("de", {31'd0, o_data_enable}, {31'd0, e_de});
        chk("rgb", {8'd0, o_red, o_green, o_blue}, {8'd0, e_rgb});
        if (e_de && m_mode == 2'd3 && x2 == 5 && y2 == 2)
            chk("ext_y2_x5", {8'd0, o_red, o_green, o_blue}, 32'h000205);
        if (e_de && m_mode == 2'd2 && x2 == 2 && y2 == 0)
            chk("chk_x2_y0", {8'd0, o_red, o_green, o_blue}, 32'h000000);
`ifdef LCD_SYNC_OUT_EN
        chk("hsync", {31'd0, o_hsync}, (c2 < 0) ? 32'd0 : {31'd0, h2 >= 1});
        chk("vsync", {31'd0, o_vsync}, (c2 < 0) ? 32'd0 : {31'd0, v2 >= 1});
`endif
        if (o_data_enable) de_count++;
        i_pixel = {8'h00, o_y[7:0], o_x[7:0]};
    endtask

    initial begin
        rst_n   = 1'b0;
        i_mode  = 2'd0;
        i_color = 24'hFF0000;
        i_pixel = 24'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_blank("reset");
        chk("reset_lcd_clk", {31'd0, o_lcd_clk}, 32'd1);
        rst_n = 1'b1;
        base  = k;

        de_count = 0;
        repeat (144) step();
        chk("de_per_2_frames", de_count, 32'd64);

        i_mode = 2'd1;
        repeat (72) step();

        i_mode = 2'd3;
        repeat (72) step();

        i_mode  = 2'd0;
        i_color = 24'h00FF00;
        repeat (36) step();
        i_mode = 2'd2;
        repeat (137) step();

        // Counters now sit at h=5, v=2 with DE active.
        chk("de_before_reset", {31'd0, o_data_enable}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_blank("async_reset");
        repeat (3) @(posedge clk);
        k += 3;
        @(negedge clk);
        check_blank("held_reset");
        rst_n    = 1'b1;
        base     = k;
        m_mode   = 2'd0;
        m_color  = 24'h0;
        pend     = 1'b0;
        de_count = 0;
        repeat (15) step();
        chk("no_de_before_16", de_count, 32'd0);
        step();
        chk("first_de_at_16", {31'd0, o_data_enable}, 32'd1);
        repeat (72) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_pattern_driver.md
Name: lcd_pattern_driver

Overview:
Parametrised successor to the fixed solid-colour LCD driver. It generates DE-mode panel timing for an arbitrary resolution and porch set, and produces pixel coordinates for downstream game and graphics logic. It drives 24-bit RGB from one of four run-time modes: solid colour, colour bars, checkerboard, or an external pixel source. It sits between the PLL pixel clock and the panel pins and is the future host for the pong renderer through the external-pixel mode.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_BACK, 46, blank clocks at line start, before active
H_FRONT, 210, blank clocks after active
V_ACTIVE, 480, visible lines per frame
V_BACK, 23, blank lines before active
V_FRONT, 22, blank lines after active
CHECK_LOG2, 5, checkerboard cell size = 2^CHECK_LOG2 pixels
XW, 11, width of o_x; YW, 10, width of o_y; each must hold its ACTIVE-1

Ports:
i_clk  in  1  pixel clock
i_rst_n  in  1  asynchronous active-low reset
i_mode  in  2  0 solid, 1 bars, 2 checker, 3 external
i_color  in  24  {R,G,B} colour for solid/checker modes
i_pixel  in  24  external pixel; must be valid one cycle after o_req
o_lcd_clk  out  1  panel clock = ~i_clk
o_req  out  1  pixel request, one cycle ahead of o_data_enable
o_x  out  XW  active column for o_req, 0..H_ACTIVE-1
o_y  out  YW  active line for o_req, 0..V_ACTIVE-1
o_frame_start  out  1  one-cycle pulse at counter origin (h=0, v=0)
o_data_enable  out  1  panel DE
o_red, o_green, o_blue  out  8 each  panel colour

Behaviour:
- Reset asynchronous, active-low. All outputs are 0 during and immediately after reset except o_lcd_clk. h/v counters = 0; latched mode = 0; latched colour = 0.
- Totals: H_TOTAL = H_BACK+H_ACTIVE+H_FRONT; V_TOTAL = V_BACK+V_ACTIVE+V_FRONT.
- h counts 0..H_TOTAL-1 and wraps to 0. v increments when h wraps, counts 0..V_TOTAL-1 and wraps.
- Active region: h in [H_BACK, H_BACK+H_ACTIVE) and v in [V_BACK, V_BACK+V_ACTIVE).
- Stage 1 (registered from the counters):
  - o_req = active.
  - o_x = h-H_BACK and o_y = v-V_BACK when active; otherwise o_x and o_y hold 0.
  - o_frame_start = (h==0 && v==0).
- Stage 2: o_data_enable = registered o_req. Colour is registered from the stage-1 coordinates or i_pixel. Blank cycles output RGB 0.
- Latency: counter state to o_req is 1 cycle; o_req to DE/RGB is 1 cycle.
- i_mode and i_color are latched only on the cycle o_frame_start is asserted, so a mid-frame change takes effect at the next frame with no tearing.
- Mode 0: RGB = latched colour.
- Mode 1: eight bars, BAR_W = H_ACTIVE/8 (integer, elaboration-time). Bar index = o_x/BAR_W, tracked with a counter, saturating at 7. Order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- Mode 2: RGB = latched colour if o_x[CHECK_LOG2]^o_y[CHECK_LOG2] is 0, else 000000.
- Mode 3: RGB = i_pixel, sampled on the cycle after o_req.
- Reset mid-frame: output blanks immediately; timing restarts at h=0, v=0, and o_frame_start asserts on the first clock after release.

Optional Feature:
LCD_SYNC_OUT_EN:
- Defined: adds outputs o_hsync and o_vsync (active-low, stage-2 aligned).
  - o_hsync is low for the first H_BACK/2 (min 1) clocks of each line.
  - o_vsync is low for the first V_BACK/2 (min 1) lines.
- Undefined: these ports and their logic are absent; the driver is DE-only.

Test Plan:
All scenarios use H_ACTIVE=8, H_BACK=2, H_FRONT=2, V_ACTIVE=4, V_BACK=1, V_FRONT=1 (H_TOTAL=12, frame=72 clocks) unless stated.
- Reset release, mode 0, i_color=FF0000 -> o_frame_start at clock 1 after release, then every 72 clocks. DE high for 8 consecutive clocks, 4 runs per frame, 32 DE clocks per frame, RGB FF0000 whenever DE is high, RGB 0 whenever DE is low.
- Mode 1 -> per active line, RGB sequence FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- Mode 3, bench returns i_pixel={o_y,o_x} (zero-extended) one cycle after o_req -> RGB for line 2, column 5 = 000205 when DE is high. o_req leads DE by exactly 1 clock.
- Change i_mode 0->2 mid-frame, CHECK_LOG2=1 -> rest of frame stays solid. The next frame shows a 2x2 checker: (0,0)=colour, (2,0)=000000, (2,2)=colour.
- Assert i_rst_n low at h=5, v=2 for 3 clocks -> outputs 0 asynchronously. The frame restarts from the origin, and the first DE rises 1*12+2+2 = 16 clocks after release.
- LCD_SYNC_OUT_EN defined -> o_hsync low 1 clock per line, o_vsync low for 12 clocks per frame, both aligned with stage-2 outputs.
